// File: rtl/spi_tx.sv
`timescale 1ns/1ps
// SPI mode-0 initiator: serialises WIDTH-bit bytes MSB-first on sclk/cs/mosi,
// keeping cs low across a multi-byte frame until a byte flagged tx_last completes.
module spi_tx #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  output logic             busy,
  output logic             done
);

  localparam int PH_MAX = (CLK_DIV > CS_SETUP)
                          ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                          : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_LINGER,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shift_q;
  logic             last_q;
  logic             load, shift_en, done_d, accept;
  logic             tx_ready_q, sclk_q, cs_q, mosi_q, busy_q, done_q;

  assign accept = tx_valid & tx_ready_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q + 1'b1;
    bit_d    = bit_q;
    load     = 1'b0;
    shift_en = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (accept) begin
          state_d = S_SETUP;
          load    = 1'b1;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (ph_q == PH_W'(CS_SETUP - 1)) begin
          state_d = S_LOW;
          ph_d    = '0;
        end
      end
      S_LOW: begin
        if (ph_q == PH_W'(CLK_DIV - 1)) begin
          state_d = S_HIGH;
          ph_d    = '0;
        end
      end
      S_HIGH: begin
        if (ph_q == PH_W'(CLK_DIV - 1)) begin
          ph_d = '0;
          if (bit_q == BC_W'(WIDTH - 1)) begin
            done_d  = 1'b1;
            state_d = last_q ? S_HOLD : S_LINGER;
          end else begin
            shift_en = 1'b1;
            bit_d    = bit_q + 1'b1;
            state_d  = S_LOW;
          end
        end
      end
      S_LINGER: begin
        ph_d = '0;
        if (accept) begin
          state_d = S_LOW;
          load    = 1'b1;
          bit_d   = '0;
        end
      end
      S_HOLD: begin
        if (ph_q == PH_W'(CS_HOLD - 1)) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
    end
  end

  // Pins are a registered decode of the current state, so they trail state_q by one clk;
  // tx_ready looks at state_d so it drops on the very edge that accepts a byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_ready_q <= (state_d == S_IDLE) || (state_d == S_LINGER);
      sclk_q     <= (state_q == S_HIGH);
      cs_q       <= (state_q == S_IDLE);
      mosi_q     <= (state_q == S_IDLE) ? 1'b0 : shift_q[WIDTH-1];
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= tx_data;
      last_q  <= tx_last;
    end else if (shift_en) begin
      shift_q <= shift_q << 1;
    end
  end

  assign tx_ready = tx_ready_q;
  assign sclk     = sclk_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_tx.sv
`timescale 1ns/1ps
// Bench for spi_tx: behavioural SPI receiver plus expected-byte queue, one task per scenario.
module tb_spi_tx;
  localparam int W = 8, DIV = 4, SET = 2, HLD = 2;
  localparam int BYTE_CLK = 2 * DIV * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_last = 1'b0;
  logic         tx_ready, sclk, cs, mosi, busy, done;

  spi_tx #(.WIDTH(W), .CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .sclk(sclk), .cs(cs), .mosi(mosi), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, rises = 0, dones = 0, viol = 0, period_bad = 0, cs_rises = 0;
  int cs_fall_cyc = 0, cs_low_len = 0, acc_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0;
  int acc_rises = 0, acc_dones = 0, nb = 0;
  bit acc_pending = 0;
  logic sclk_p = 1'b0, mosi_p = 1'b0, cs_p = 1'b1, done_p = 1'b0;
  logic [W-1:0] sh = '0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] expq[$];

  // Receiver and line monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc++;
    if (cs) nb = 0;
    if (sclk && !sclk_p) begin
      if (acc_pending) begin first_rise_cyc = cyc; acc_pending = 0; end
      if (nb != 0 && (cyc - last_rise_cyc) != 2 * DIV) period_bad++;
      last_rise_cyc = cyc;
      rises++;
      if (!cs) begin
        sh = {sh[W-2:0], mosi};
        nb++;
        if (nb == W) begin rxq.push_back(sh); nb = 0; end
      end
    end
    if (sclk && (mosi !== mosi_p)) viol++;
    if (sclk && cs) viol++;
    if (!cs && cs_p) cs_fall_cyc = cyc;
    if (cs && !cs_p) begin cs_low_len = cyc - cs_fall_cyc; cs_rises++; end
    if (done) begin dones++; if (done_p) viol++; end
    if (tx_valid && tx_ready) begin
      acc_cyc = cyc + 1; acc_pending = 1; acc_rises = rises; acc_dones = dones;
    end
    sclk_p = sclk; mosi_p = mosi; cs_p = cs; done_p = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic int q_diff();
    int n;
    n = (rxq.size() > expq.size()) ? rxq.size() - expq.size() : expq.size() - rxq.size();
    for (int i = 0; i < rxq.size() && i < expq.size(); i++)
      if (rxq[i] !== expq[i]) n++;
    return n;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic last, input bit exp_rx, output bit ok);
    tx_data = d; tx_last = last; tx_valid = 1'b1; ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = W'($urandom); tx_last = 1'($urandom);
    if (ok && exp_rx) expq.push_back(d);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cs && !busy && tx_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cs, sclk, mosi, busy, done} !== 5'b10000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=10000", {cs, sclk, mosi, busy, done});
    end
    total++;
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", tx_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", tx_ready); end
    @(posedge clk); #1;
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", tx_ready); end
  endtask

  task automatic test_single();
    bit ok; int b_d, b_r;
    rxq.delete(); expq.delete(); b_d = dones; b_r = rises;
    send(8'hA5, 1'b1, 1, ok);
    total++;
    if (!ok || busy !== 1'b1 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL single_accept got=ok%0d busy%b rdy%b exp=ok1 busy1 rdy0", ok, busy, tx_ready);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_idle got=timeout exp=idle"); end
    total++;
    if (dones - b_d != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", dones - b_d); end
    total++;
    if (rises - b_r != W) begin bad++; $display("FAIL single_rises got=%0d exp=%0d", rises - b_r, W); end
    total++;
    if (cs_low_len != SET + BYTE_CLK + HLD) begin
      bad++; $display("FAIL single_cs_low got=%0d exp=%0d", cs_low_len, SET + BYTE_CLK + HLD);
    end
    total++;
    if (q_diff() != 0) begin bad++; $display("FAIL single_rx got=%0d diffs exp=0", q_diff()); end
  endtask

  task automatic test_frame();
    bit ok1, ok2, ok; int b_d, b_r, b_c;
    rxq.delete(); expq.delete(); b_d = dones; b_r = rises; b_c = cs_rises;
    send(8'hA5, 1'b0, 1, ok1);
    send(8'hB3, 1'b1, 1, ok2);
    wait_idle(ok);
    total++;
    if (!(ok1 && ok2 && ok)) begin bad++; $display("FAIL frame_handshake got=%0d%0d%0d exp=111", ok1, ok2, ok); end
    total++;
    if (cs_rises - b_c != 1) begin bad++; $display("FAIL frame_cs_rises got=%0d exp=1", cs_rises - b_c); end
    total++;
    if (dones - b_d != 2) begin bad++; $display("FAIL frame_done got=%0d exp=2", dones - b_d); end
    total++;
    if (rises - b_r != 2 * W) begin bad++; $display("FAIL frame_rises got=%0d exp=%0d", rises - b_r, 2 * W); end
    total++;
    if (cs_low_len != SET + 2 * BYTE_CLK + 1 + HLD) begin
      bad++; $display("FAIL frame_cs_low got=%0d exp=%0d", cs_low_len, SET + 2 * BYTE_CLK + 1 + HLD);
    end
    total++;
    if (q_diff() != 0) begin bad++; $display("FAIL frame_rx got=%0d diffs exp=0", q_diff()); end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, ok; int b_d, b_r, v0;
    rxq.delete(); expq.delete(); b_d = dones; b_r = rises; v0 = viol;
    send(W'($urandom), 1'b0, 1, ok1);
    send(8'h3C, 1'b1, 1, ok2);
    total++;
    if (acc_rises - b_r != W || acc_dones - b_d != 1) begin
      bad++; $display("FAIL bp_accept_point got=rises%0d dones%0d exp=rises%0d dones1",
                      acc_rises - b_r, acc_dones - b_d, W);
    end
    wait_idle(ok);
    total++;
    if (!(ok1 && ok2 && ok)) begin bad++; $display("FAIL bp_handshake got=%0d%0d%0d exp=111", ok1, ok2, ok); end
    total++;
    if (viol != v0) begin bad++; $display("FAIL bp_line_rules got=%0d violations exp=0", viol - v0); end
    total++;
    if (q_diff() != 0) begin bad++; $display("FAIL bp_rx got=%0d diffs exp=0", q_diff()); end
  endtask

  task automatic test_timing();
    bit ok; int pb0, v0;
    rxq.delete(); expq.delete(); pb0 = period_bad; v0 = viol;
    send(W'($urandom), 1'b1, 1, ok);
    wait_idle(ok);
    total++;
    if (cs_fall_cyc - acc_cyc != 1) begin bad++; $display("FAIL timing_cs_fall got=%0d exp=1", cs_fall_cyc - acc_cyc); end
    total++;
    if (first_rise_cyc - acc_cyc != 1 + SET + DIV) begin
      bad++; $display("FAIL timing_first_rise got=%0d exp=%0d", first_rise_cyc - acc_cyc, 1 + SET + DIV);
    end
    total++;
    if (period_bad != pb0 || viol != v0) begin
      bad++; $display("FAIL timing_period got=%0d/%0d bad exp=0/0", period_bad - pb0, viol - v0);
    end
    total++;
    if (q_diff() != 0) begin bad++; $display("FAIL timing_rx got=%0d diffs exp=0", q_diff()); end
  endtask

  task automatic test_reset_mid();
    bit ok, reached; int b_d, b_r;
    rxq.delete(); expq.delete(); b_d = dones; b_r = rises; reached = 0;
    send(W'($urandom), 1'b1, 0, ok);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rises - b_r >= 4) begin reached = 1; break; end
    end
    total++;
    if (!reached) begin bad++; $display("FAIL rstmid_progress got=%0d rises exp=4", rises - b_r); end
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    total++;
    if ({cs, sclk, mosi, busy, done, tx_ready} !== 6'b100000) begin
      bad++; $display("FAIL rstmid_async got=%b exp=100000", {cs, sclk, mosi, busy, done, tx_ready});
    end
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (dones != b_d) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", dones - b_d); end
    send(8'h5A, 1'b1, 1, ok);
    wait_idle(ok);
    total++;
    if (!ok || q_diff() != 0 || rxq.size() != 1) begin
      bad++; $display("FAIL rstmid_resend got=%0d bytes %0d diffs exp=1 bytes 0 diffs", rxq.size(), q_diff());
    end
  endtask

  task automatic test_linger();
    bit ok, rdy; int badcyc, b_d;
    rxq.delete(); expq.delete(); badcyc = 0; rdy = 0; b_d = dones;
    send(8'hFF, 1'b0, 1, ok);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin rdy = 1; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs !== 1'b0 || sclk !== 1'b0) badcyc++;
    end
    total++;
    if (!rdy || badcyc != 0) begin bad++; $display("FAIL linger_hold got=rdy%0d bad%0d exp=rdy1 bad0", rdy, badcyc); end
    @(posedge clk); #1;
    send(8'h00, 1'b1, 1, ok);
    wait_idle(ok);
    total++;
    if (first_rise_cyc - acc_cyc != 1 + DIV) begin
      bad++; $display("FAIL linger_first_rise got=%0d exp=%0d", first_rise_cyc - acc_cyc, 1 + DIV);
    end
    total++;
    if (q_diff() != 0 || dones - b_d != 2) begin
      bad++; $display("FAIL linger_rx got=%0d diffs %0d dones exp=0 diffs 2 dones", q_diff(), dones - b_d);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok; int nbytes, n, b_d, b_r, b_c, v0, pb0;
    rxq.delete(); expq.delete(); nbytes = 0; all_ok = 1;
    b_d = dones; b_r = rises; b_c = cs_rises; v0 = viol; pb0 = period_bad;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
        send(W'($urandom), 1'(j == n - 1), 1, ok);
        all_ok &= ok;
        nbytes++;
      end
    end
    wait_idle(ok);
    all_ok &= ok;
    total++;
    if (!all_ok) begin bad++; $display("FAIL b2b_handshake got=0 exp=1"); end
    total++;
    if (cs_rises - b_c != 4) begin bad++; $display("FAIL b2b_frames got=%0d exp=4", cs_rises - b_c); end
    total++;
    if (dones - b_d != nbytes || rises - b_r != W * nbytes) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", dones - b_d, rises - b_r, nbytes, W * nbytes);
    end
    total++;
    if (viol != v0 || period_bad != pb0) begin
      bad++; $display("FAIL b2b_line_rules got=%0d/%0d exp=0/0", viol - v0, period_bad - pb0);
    end
    total++;
    if (q_diff() != 0) begin bad++; $display("FAIL b2b_rx got=%0d diffs exp=0", q_diff()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_backpressure();
    test_timing();
    test_reset_mid();
    test_linger();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
